// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: an instruction port and a data port share one bus.
// Alternating priority under contention, single outstanding transaction, cycle-count timeout.
module mem_arbiter #(
    parameter int ADDR_W  = 27,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [31:0]       i_q,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_data,
    output logic              d_ready,
    output logic [31:0]       d_q,
    output logic              bus_start,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_data,
    input  logic [31:0]       bus_q,
    input  logic              bus_done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;
    typedef enum logic {GRANT_I, GRANT_D} grant_t;

    // Counter holds the number of BUSY cycles already completed, so the
    // TIMEOUT-th BUSY cycle is the one where it equals TIMEOUT-1.
    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

    state_t     state, state_nx;
    grant_t     last_grant;
    logic [9:0] cnt;
    logic       grant_i, grant_d, finish, expire, busy;

    assign busy = (state == BUSY_I) || (state == BUSY_D);

    always_comb begin
        state_nx = state;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        finish   = 1'b0;
        expire   = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    grant_i = (last_grant == GRANT_D);
                    grant_d = (last_grant == GRANT_I);
                end else begin
                    grant_i = i_req;
                    grant_d = d_req;
                end
                if (grant_i)
                    state_nx = BUSY_I;
                else if (grant_d)
                    state_nx = BUSY_D;
            end
            BUSY_I, BUSY_D: begin
                if (bus_done)
                    finish = 1'b1;
                else if (cnt == CNT_LAST)
                    expire = 1'b1;
                if (finish || expire)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            cnt        <= '0;
            i_ready    <= 1'b0;
            d_ready    <= 1'b0;
            i_q        <= '0;
            d_q        <= '0;
            bus_start  <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_data   <= '0;
            err        <= 1'b0;
        end else begin
            state     <= state_nx;
            bus_start <= grant_i | grant_d;
            i_ready   <= (state == BUSY_I) && (finish || expire);
            d_ready   <= (state == BUSY_D) && (finish || expire);
            err       <= expire;

            if (grant_i) begin
                last_grant <= GRANT_I;
                cnt        <= '0;
                bus_we     <= 1'b0;
                bus_addr   <= i_addr;
                bus_data   <= '0;
            end else if (grant_d) begin
                last_grant <= GRANT_D;
                cnt        <= '0;
                bus_we     <= d_we;
                bus_addr   <= d_addr;
                bus_data   <= d_data;
            end else if (busy) begin
                cnt <= cnt + 10'd1;
            end

            if ((state == BUSY_I) && (finish || expire))
                i_q <= finish ? bus_q : '1;
            if ((state == BUSY_D) && (finish || expire))
                d_q <= finish ? bus_q : '1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected bus transactions and ready results are
// queued as requests are driven, then popped and compared as the DUT produces them.
module tb_mem_arbiter;

    localparam int AW = 27;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [31:0]   d_data = '0;
    logic          i_ready, d_ready, bus_start, bus_we, err;
    logic [31:0]   i_q, d_q, bus_data;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_q;
    logic          bus_done = 1'b0;

    mem_arbiter #(.ADDR_W(AW), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_q(i_q),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_data(d_data),
        .d_ready(d_ready), .d_q(d_q),
        .bus_start(bus_start), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_data(bus_data), .bus_q(bus_q), .bus_done(bus_done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus responder: pulses bus_done resp_lat cycles after seeing bus_start.
    int          resp_lat = 0;
    bit          resp_never = 1'b0;
    bit          tie_high = 1'b0;
    logic [31:0] resp_data = '0;
    bit          resp_active = 1'b0;
    int          resp_wait = 0;
    assign bus_q = resp_data;

    always @(negedge clk) begin
        bus_done = 1'b0;
        if (bus_start && !resp_never) begin
            resp_active = 1'b1;
            resp_wait   = resp_lat;
        end
        if (resp_active) begin
            if (resp_wait == 0) begin
                bus_done    = 1'b1;
                resp_active = 1'b0;
            end else begin
                resp_wait--;
            end
        end
        if (tie_high) bus_done = 1'b1;
    end

    typedef struct { logic we; logic [AW-1:0] addr; logic [31:0] data; } bus_t;
    typedef struct { bit is_d; logic [31:0] q; bit err; } rdy_t;

    bus_t bq[$];
    rdy_t rq[$];
    bus_t cur;
    bit   cur_valid = 1'b0;

    logic [31:0] exp_iq = '0, exp_dq = '0;
    int n_cmp = 0, n_bad = 0;
    int last_start = 0, prev_start = 0, last_ready = 0, prev_ready = 0;

    // Scoreboard consumer: pops bus and ready expectations as the DUT shows them.
    task automatic drain(input int budget, input bit release_req);
        int   n = 0;
        rdy_t r;
        while (rq.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
            if (bus_start) begin
                if (bq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL bus_start_unexpected cycle=%0d", cyc);
                end else begin
                    cur = bq.pop_front();
                    cur_valid  = 1'b1;
                    prev_start = last_start;
                    last_start = cyc;
                end
            end
            if (cur_valid) begin
                n_cmp++;
                if ({bus_we, bus_addr, bus_data} !== {cur.we, cur.addr, cur.data}) begin
                    n_bad++;
                    $display("FAIL bus_fields got we=%0b addr=%h data=%h exp we=%0b addr=%h data=%h",
                             bus_we, bus_addr, bus_data, cur.we, cur.addr, cur.data);
                end
            end
            if (i_ready || d_ready) begin
                r = rq.pop_front();
                prev_ready = last_ready;
                last_ready = cyc;
                n_cmp++;
                if ({i_ready, d_ready} !== (r.is_d ? 2'b01 : 2'b10)) begin
                    n_bad++;
                    $display("FAIL ready_who got i=%0b d=%0b exp is_d=%0b", i_ready, d_ready, r.is_d);
                end
                if (r.is_d) exp_dq = r.q; else exp_iq = r.q;
                n_cmp++;
                if ({i_q, d_q, err} !== {exp_iq, exp_dq, r.err}) begin
                    n_bad++;
                    $display("FAIL q_err got i_q=%h d_q=%h err=%0b exp i_q=%h d_q=%h err=%0b",
                             i_q, d_q, err, exp_iq, exp_dq, r.err);
                end
                cur_valid = 1'b0;
                if (release_req) begin
                    if (i_ready) i_req = 1'b0;
                    if (d_ready) d_req = 1'b0;
                end
            end else if (err) begin
                n_cmp++; n_bad++;
                $display("FAIL err_without_ready got err=1 exp 0 cycle=%0d", cyc);
            end
        end
        if (rq.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_budget got %0d pending exp 0", rq.size());
        end
        rq.delete();
        bq.delete();
        cur_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        tie_high = 1'b0; resp_never = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({i_ready, d_ready, bus_start, bus_we, err} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags got %b exp 00000", {i_ready, d_ready, bus_start, bus_we, err});
        end
        n_cmp++;
        if ({i_q, d_q, bus_addr, bus_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_data got i_q=%h d_q=%h addr=%h data=%h exp 0", i_q, d_q, bus_addr, bus_data);
        end
        exp_iq = '0; exp_dq = '0;
        reset = 1'b1;
    endtask

    task automatic test_single_fetch();
        int req_cyc;
        resp_lat = 1; resp_data = 32'hDEADBEEF;
        bq.push_back('{we: 1'b0, addr: 27'h100, data: 32'h0});
        rq.push_back('{is_d: 1'b0, q: 32'hDEADBEEF, err: 1'b0});
        i_addr = 27'h100; i_req = 1'b1;
        req_cyc = cyc;
        drain(20, 1'b1);
        n_cmp++;
        if (last_start - req_cyc !== 1) begin
            n_bad++;
            $display("FAIL fetch_start_latency got %0d exp 1", last_start - req_cyc);
        end
        n_cmp++;
        if (last_ready - last_start !== 2) begin
            n_bad++;
            $display("FAIL fetch_ready_latency got %0d exp 2", last_ready - last_start);
        end
        @(negedge clk);
        n_cmp++;
        if ({i_ready, d_ready, bus_start} !== 3'b0) begin
            n_bad++;
            $display("FAIL fetch_pulse_width got %b exp 000", {i_ready, d_ready, bus_start});
        end
    endtask

    task automatic test_write();
        resp_lat = 2; resp_data = 32'hA5A50001;
        bq.push_back('{we: 1'b1, addr: 27'h2000, data: 32'h12345678});
        rq.push_back('{is_d: 1'b1, q: 32'hA5A50001, err: 1'b0});
        d_addr = 27'h2000; d_data = 32'h12345678; d_we = 1'b1; d_req = 1'b1;
        drain(20, 1'b1);
        n_cmp++;
        if (last_ready - last_start !== 3) begin
            n_bad++;
            $display("FAIL write_latency got %0d exp 3", last_ready - last_start);
        end
        d_we = 1'b0;
    endtask

    task automatic test_timeout();
        resp_never = 1'b1; resp_data = 32'h0;
        bq.push_back('{we: 1'b0, addr: 27'h300, data: 32'h0});
        rq.push_back('{is_d: 1'b0, q: 32'hFFFFFFFF, err: 1'b1});
        i_addr = 27'h300; i_req = 1'b1;
        drain(30, 1'b1);
        n_cmp++;
        if (last_ready - last_start !== 8) begin
            n_bad++;
            $display("FAIL timeout_busy_cycles got %0d exp 8", last_ready - last_start);
        end
        @(negedge clk);
        n_cmp++;
        if ({err, i_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL timeout_pulse_width got err=%0b i_ready=%0b exp 0 0", err, i_ready);
        end
        resp_never = 1'b0;
    endtask

    task automatic test_back_to_back();
        test_reset();
        resp_lat = 0; resp_data = 32'h0BADF00D;
        i_addr = 27'h200; d_addr = 27'h1000; d_data = 32'h55; d_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                bq.push_back('{we: 1'b0, addr: 27'h1000, data: 32'h55});
                rq.push_back('{is_d: 1'b1, q: 32'h0BADF00D, err: 1'b0});
            end else begin
                bq.push_back('{we: 1'b0, addr: 27'h200, data: 32'h0});
                rq.push_back('{is_d: 1'b0, q: 32'h0BADF00D, err: 1'b0});
            end
        end
        i_req = 1'b1; d_req = 1'b1;
        drain(40, 1'b0);
        i_req = 1'b0; d_req = 1'b0;
        n_cmp++;
        if (last_ready - prev_ready !== 3) begin
            n_bad++;
            $display("FAIL alternate_spacing got %0d exp 3", last_ready - prev_ready);
        end
    endtask

    task automatic test_reset_mid_busy();
        int n = 0;
        resp_lat = 3; resp_data = 32'hCAFE0000;
        d_addr = 27'h40; d_data = 32'h99; d_we = 1'b1; d_req = 1'b1;
        while (!bus_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (bus_start !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_start got %0b exp 1", bus_start);
        end
        reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_iq = '0; exp_dq = '0;
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if ({i_ready, d_ready, bus_start, bus_we, err, i_q, d_q, bus_addr, bus_data} !== '0) begin
                n_bad++;
                $display("FAIL midreset_outputs k=%0d got rdy=%0b%0b start=%0b err=%0b d_q=%h addr=%h exp all 0",
                         k, i_ready, d_ready, bus_start, err, d_q, bus_addr);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_zero_wait();
        tie_high = 1'b1; resp_data = 32'h77;
        i_addr = 27'h500;
        for (int k = 0; k < 4; k++) begin
            bq.push_back('{we: 1'b0, addr: 27'h500, data: 32'h0});
            rq.push_back('{is_d: 1'b0, q: 32'h77, err: 1'b0});
        end
        i_req = 1'b1;
        drain(40, 1'b0);
        i_req = 1'b0;
        n_cmp++;
        if (last_ready - prev_ready !== 3) begin
            n_bad++;
            $display("FAIL zero_wait_ready_period got %0d exp 3", last_ready - prev_ready);
        end
        n_cmp++;
        if (last_start - prev_start !== 3) begin
            n_bad++;
            $display("FAIL zero_wait_start_period got %0d exp 3", last_start - prev_start);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus_start, i_ready, d_ready} !== 3'b0) begin
                n_bad++;
                $display("FAIL zero_wait_idle k=%0d got %b exp 000", k, {bus_start, i_ready, d_ready});
            end
        end
        tie_high = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_write();
        test_timeout();
        test_back_to_back();
        test_reset_mid_busy();
        test_zero_wait();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got time=%0t exp finish earlier", $time);
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 27, address width of the requester and bus address ports.
REQ-002 Parameter: TIMEOUT, 1023, number of BUSY cycles without bus_done before the transaction is aborted.
REQ-003 Port: clk  in  1  system clock; all state changes on the rising edge.
REQ-004 Port: reset  in  1  synchronous, active-low reset (asserted while 0, sampled on clk).
REQ-005 Ports, instruction requester: i_req in 1; i_addr in ADDR_W; i_ready out 1; i_q out 32 (read-only requester).
REQ-006 Ports, data requester: d_req in 1; d_we in 1; d_addr in ADDR_W; d_data in 32; d_ready out 1; d_q out 32.
REQ-007 Ports, shared bus: bus_start out 1; bus_we out 1; bus_addr out ADDR_W; bus_data out 32; bus_q in 32; bus_done in 1.
REQ-008 Port: err out 1; one-cycle pulse marking a timed-out transaction.

Function
REQ-009 The FSM SHALL have exactly four states: IDLE, BUSY_I, BUSY_D, DONE.
REQ-010 IDLE, no req high: stay in IDLE.
REQ-011 IDLE, exactly one req high: grant that requester; latch its addr, and for the data requester also we and data, into bus_addr/bus_we/bus_data; go to BUSY_I or BUSY_D.
REQ-012 IDLE, i_req and d_req both high: grant the requester not recorded in last_grant.
REQ-013 last_grant SHALL update on every grant.
REQ-014 Instruction grants SHALL drive bus_we=0 and bus_data=0.
REQ-015 bus_start SHALL be high for exactly the first cycle of BUSY_x and low otherwise.
REQ-016 bus_addr, bus_we and bus_data SHALL stay constant from grant until leaving DONE.
REQ-017 In BUSY_x, bus_done sampled high SHALL capture bus_q into the granted requester's q register and go to DONE.
REQ-018 The other requester's q SHALL be unchanged.
REQ-019 A bus_done that is high in the same cycle as bus_start SHALL be accepted.
REQ-020 A 10-bit timeout counter SHALL clear on grant and increment each BUSY cycle.
REQ-021 If the counter reaches TIMEOUT without bus_done, the FSM SHALL go to DONE with q set to 32'hFFFFFFFF and err pulsed high during the DONE cycle.
REQ-022 In DONE, the granted requester's ready SHALL be high for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-023 Requesters hold req (and addr/we/data) until they see ready; a req still high in IDLE after DONE is a new request.
REQ-024 bus_done sampled in IDLE or DONE SHALL be ignored.
REQ-025 i_q and d_q SHALL hold their last value until overwritten by a completed or timed-out transaction of that requester.
REQ-026 Minimum latency: req high at edge N in IDLE -> bus_start during cycle N+1 -> bus_done at edge N+1 -> ready high during cycle N+2.
REQ-027 Only one transaction SHALL be outstanding at any time; no pipelining.
REQ-028 Write transactions (d_we=1) SHALL still return bus_q into d_q on completion.

Reset
REQ-029 On reset=0 at a rising edge: state=IDLE, last_grant=I, counter=0.
REQ-030 On the same reset edge, all outputs SHALL go to 0: i_ready, d_ready, i_q, d_q, bus_start, bus_we, bus_addr, bus_data, err.
REQ-031 Reset asserted mid-transaction SHALL abort it with no ready or err pulse.
REQ-032 A late bus_done arriving after reset SHALL be ignored (REQ-024).

Verification
REQ-033 Single fetch: i_req=1, i_addr=0x100, bus_done one cycle after bus_start with bus_q=0xDEADBEEF -> bus_we=0, bus_addr=0x100, i_ready one cycle, i_q=0xDEADBEEF, d_q unchanged.
REQ-034 Simultaneous requests after reset: i_req=d_req=1 held -> D granted first, then I, then D, alternating; each ready is a one-cycle pulse.
REQ-035 Write: d_req=1, d_we=1, d_addr=0x2000, d_data=0x12345678 -> bus_we=1, bus_data=0x12345678 stable through DONE, d_ready pulse.
REQ-036 Timeout: TIMEOUT=8, bus_done held low -> DONE after 8 BUSY cycles, err and i_ready (or d_ready) pulse together, q=0xFFFFFFFF.
REQ-037 Reset mid-BUSY_D, then bus_done pulsed -> all outputs 0, state IDLE, no ready or err, d_q=0.
REQ-038 Zero-wait bus (bus_done tied high) with continuous i_req -> i_ready every 3rd cycle, bus_start every 3rd cycle.
